// File: rtl/lsu.sv
// Load/store unit between the RV32I core EXECUTE stage and the word-addressed RAM.
// Define LSU_IO_EN to build the IO page (LED register and cycle counter selected by addr[22]).
module lsu #(
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RESETN,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_is_store,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_error,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_wmask,
  output logic                  mem_rstrb,
  input  logic [31:0]           mem_rdata,
  output logic [3:0]            leds
);

  typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, RESP} state_t;

  state_t                state_q, state_d;
  logic [2:0]            f3_q, f3_d;
  logic [1:0]            alo_q, alo_d;
  logic                  rsp_valid_d, rsp_error_d, mem_rstrb_d;
  logic [31:0]           rsp_rdata_d, mem_wdata_d;
  logic [ADDR_WIDTH-1:0] mem_addr_d;
  logic [3:0]            wmask_q, wmask_d;
  logic                  accept, misaligned, illegal, req_err, io_hit;
  logic [31:0]           io_rdata, shifted, load_ext;
  logic                  unused_addr_bits;

  assign req_ready        = (state_q == IDLE) && RESETN;
  assign accept           = req_valid && req_ready;
  // Gate the strobe so a write in flight when reset asserts never commits.
  assign mem_wmask        = RESETN ? wmask_q : 4'b0000;
  assign unused_addr_bits = ^req_addr;

`ifdef LSU_IO_EN
  logic [31:0] cycle_q;
  logic [3:0]  leds_q;

  assign io_hit = req_addr[22];
  assign leds   = leds_q;

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      cycle_q <= 32'd0;
      leds_q  <= 4'd0;
    end else begin
      cycle_q <= cycle_q + 32'd1;
      if (accept && io_hit && req_is_store && !req_err && (req_addr[21:2] == 20'd0))
        leds_q <= req_wdata[3:0];
    end
  end

  always_comb begin
    io_rdata = 32'd0;
    if (req_addr[21:2] == 20'd0)      io_rdata = {28'd0, leds_q};
    else if (req_addr[21:2] == 20'd1) io_rdata = cycle_q;
  end
`else
  assign io_hit   = 1'b0;
  assign io_rdata = 32'd0;
  assign leds     = 4'b0000;
`endif

  // Alignment and funct3 legality, evaluated on the request being accepted.
  always_comb begin
    misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                 ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    illegal    = req_is_store ? (req_funct3 > 3'd2)
                              : ((req_funct3 == 3'd3) || (req_funct3[2:1] == 2'b11));
    req_err    = misaligned || illegal || (io_hit && (req_funct3 != 3'd2));
  end

  assign shifted = mem_rdata >> {alo_q, 3'b000};

  always_comb begin
    case (f3_q)
      3'd0:    load_ext = {{24{shifted[7]}}, shifted[7:0]};
      3'd1:    load_ext = {{16{shifted[15]}}, shifted[15:0]};
      3'd4:    load_ext = {24'd0, shifted[7:0]};
      3'd5:    load_ext = {16'd0, shifted[15:0]};
      default: load_ext = shifted;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    f3_d        = f3_q;
    alo_d       = alo_q;
    rsp_rdata_d = 32'd0;
    rsp_error_d = 1'b0;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    wmask_d     = 4'b0000;
    case (state_q)
      IDLE: begin
        if (accept) begin
          f3_d       = req_funct3;
          alo_d      = req_addr[1:0];
          mem_addr_d = req_addr[ADDR_WIDTH+1:2];
          if (req_err) begin
            state_d     = RESP;
            rsp_error_d = 1'b1;
          end else if (io_hit) begin
            state_d = RESP;
            if (!req_is_store) rsp_rdata_d = io_rdata;
          end else if (req_is_store) begin
            state_d = WRITE;
            case (req_funct3[1:0])
              2'b00: begin
                mem_wdata_d = {4{req_wdata[7:0]}};
                wmask_d     = 4'b0001 << req_addr[1:0];
              end
              2'b01: begin
                mem_wdata_d = {2{req_wdata[15:0]}};
                wmask_d     = 4'b0011 << req_addr[1:0];
              end
              default: begin
                mem_wdata_d = req_wdata;
                wmask_d     = 4'b1111;
              end
            endcase
          end else begin
            state_d = READ;
          end
        end
      end
      READ:  state_d = WAIT;
      WAIT: begin
        state_d     = RESP;
        rsp_rdata_d = load_ext;
      end
      WRITE: state_d = RESP;
      RESP:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    rsp_valid_d = (state_d == RESP);
    mem_rstrb_d = (state_d == READ);
  end

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state_q   <= IDLE;
      f3_q      <= 3'd0;
      alo_q     <= 2'd0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_error <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 32'd0;
      wmask_q   <= 4'd0;
      mem_rstrb <= 1'b0;
    end else begin
      state_q   <= state_d;
      f3_q      <= f3_d;
      alo_q     <= alo_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
      rsp_error <= rsp_error_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      wmask_q   <= wmask_d;
      mem_rstrb <= mem_rstrb_d;
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: vector table plus reset, IO page and back-to-back sequences.
module tb_lsu;

  logic        CLK = 1'b0;
  logic        RESETN = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_is_store = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_rstrb;
  logic [31:0] mem_rdata = 32'd0;
  logic [3:0]  leds;

  int checks = 0;
  int errors = 0;

  logic [31:0] ram [256] = '{default: 32'd0};

  lsu #(.ADDR_WIDTH(8)) dut (
    .CLK(CLK), .RESETN(RESETN),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rstrb(mem_rstrb), .mem_rdata(mem_rdata), .leds(leds)
  );

  always #5 CLK = ~CLK;

  // RAM: one-cycle read latency, byte-masked writes.
  always @(posedge CLK) begin
    if (mem_rstrb) mem_rdata <= ram[mem_addr];
    for (int b = 0; b < 4; b++)
      if (mem_wmask[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    req_is_store = st;
    req_funct3   = f3;
    req_addr     = a;
    req_wdata    = wd;
  endtask

  // Issue one request; report latency and what the RAM side saw up to the response.
  task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                        output int lat, output logic [31:0] rd, output logic er,
                        output int nr, output int nw, output logic [3:0] wm,
                        output logic [31:0] wdat, output logic [7:0] ma);
    int n;
    lat = 0; rd = 32'd0; er = 1'b0; nr = 0; nw = 0; wm = 4'd0; wdat = 32'd0; ma = 8'd0;
    @(negedge CLK);
    drive(st, f3, a, wd);
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge CLK);
      n++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: req_ready still low after %0d cycles", n);
      req_valid = 1'b0;
      return;
    end
    @(posedge CLK);
    do begin
      @(negedge CLK);
      lat++;
      if (lat == 1) begin
        req_valid = 1'b0;
        drive(~st, 3'd7, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
      end
      if (mem_rstrb) begin nr++; ma = mem_addr; end
      if (mem_wmask != 4'd0) begin nw++; wm = mem_wmask; wdat = mem_wdata; ma = mem_addr; end
    end while (!rsp_valid && lat < 8);
    rd = rsp_rdata;
    er = rsp_error;
  endtask

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_er;
    int          exp_lat;
    logic [3:0]  exp_wm;
    logic [31:0] exp_wdat;
  } vec_t;

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
  } op_t;

  localparam int NV = 31;
  vec_t vecs [NV];
  op_t  ops [6];

  int          lat, nr, nw, acc, rsps, k, tmo;
  logic [31:0] rd, wdat, v1, v2, a_tmp;
  logic        er, pend;
  logic [3:0]  wm;
  logic [7:0]  ma;

  initial begin
    vecs[0]  = '{1'b1, 3'd2, 32'h10,  32'h12345678, 32'h0,        1'b0, 2, 4'hF, 32'h12345678};
    vecs[1]  = '{1'b0, 3'd0, 32'h13,  32'h0,        32'h00000012, 1'b0, 3, 4'h0, 32'h0};
    vecs[2]  = '{1'b0, 3'd4, 32'h13,  32'h0,        32'h00000012, 1'b0, 3, 4'h0, 32'h0};
    vecs[3]  = '{1'b0, 3'd2, 32'h10,  32'h0,        32'h12345678, 1'b0, 3, 4'h0, 32'h0};
    vecs[4]  = '{1'b1, 3'd0, 32'h10,  32'hABCDEF80, 32'h0,        1'b0, 2, 4'h1, 32'h80808080};
    vecs[5]  = '{1'b0, 3'd0, 32'h10,  32'h0,        32'hFFFFFF80, 1'b0, 3, 4'h0, 32'h0};
    vecs[6]  = '{1'b0, 3'd4, 32'h10,  32'h0,        32'h00000080, 1'b0, 3, 4'h0, 32'h0};
    vecs[7]  = '{1'b0, 3'd2, 32'h10,  32'h0,        32'h12345680, 1'b0, 3, 4'h0, 32'h0};
    vecs[8]  = '{1'b0, 3'd1, 32'h12,  32'h0,        32'h00001234, 1'b0, 3, 4'h0, 32'h0};
    vecs[9]  = '{1'b0, 3'd0, 32'h11,  32'h0,        32'h00000056, 1'b0, 3, 4'h0, 32'h0};
    vecs[10] = '{1'b1, 3'd1, 32'h22,  32'h1234BEEF, 32'h0,        1'b0, 2, 4'hC, 32'hBEEFBEEF};
    vecs[11] = '{1'b0, 3'd1, 32'h22,  32'h0,        32'hFFFFBEEF, 1'b0, 3, 4'h0, 32'h0};
    vecs[12] = '{1'b0, 3'd5, 32'h22,  32'h0,        32'h0000BEEF, 1'b0, 3, 4'h0, 32'h0};
    vecs[13] = '{1'b0, 3'd2, 32'h20,  32'h0,        32'hBEEF0000, 1'b0, 3, 4'h0, 32'h0};
    vecs[14] = '{1'b0, 3'd2, 32'h02,  32'h0,        32'h0,        1'b1, 1, 4'h0, 32'h0};
    vecs[15] = '{1'b0, 3'd1, 32'h01,  32'h0,        32'h0,        1'b1, 1, 4'h0, 32'h0};
    vecs[16] = '{1'b1, 3'd1, 32'h03,  32'hFFFFFFFF, 32'h0,        1'b1, 1, 4'h0, 32'h0};
    vecs[17] = '{1'b0, 3'd3, 32'h00,  32'h0,        32'h0,        1'b1, 1, 4'h0, 32'h0};
    vecs[18] = '{1'b0, 3'd6, 32'h00,  32'h0,        32'h0,        1'b1, 1, 4'h0, 32'h0};
    vecs[19] = '{1'b1, 3'd4, 32'h00,  32'hFFFFFFFF, 32'h0,        1'b1, 1, 4'h0, 32'h0};
    vecs[20] = '{1'b0, 3'd2, 32'h00,  32'h0,        32'h00000000, 1'b0, 3, 4'h0, 32'h0};
    vecs[21] = '{1'b1, 3'd2, 32'h404, 32'hCAFEF00D, 32'h0,        1'b0, 2, 4'hF, 32'hCAFEF00D};
    vecs[22] = '{1'b0, 3'd2, 32'h004, 32'h0,        32'hCAFEF00D, 1'b0, 3, 4'h0, 32'h0};
    vecs[23] = '{1'b1, 3'd0, 32'h401, 32'h0000007F, 32'h0,        1'b0, 2, 4'h2, 32'h7F7F7F7F};
    vecs[24] = '{1'b0, 3'd2, 32'h00,  32'h0,        32'h00007F00, 1'b0, 3, 4'h0, 32'h0};
    vecs[25] = '{1'b0, 3'd1, 32'h00,  32'h0,        32'h00007F00, 1'b0, 3, 4'h0, 32'h0};
    vecs[26] = '{1'b0, 3'd0, 32'h01,  32'h0,        32'h0000007F, 1'b0, 3, 4'h0, 32'h0};
    vecs[27] = '{1'b1, 3'd1, 32'h00,  32'h00008001, 32'h0,        1'b0, 2, 4'h3, 32'h80018001};
    vecs[28] = '{1'b0, 3'd1, 32'h00,  32'h0,        32'hFFFF8001, 1'b0, 3, 4'h0, 32'h0};
    vecs[29] = '{1'b0, 3'd5, 32'h02,  32'h0,        32'h00000000, 1'b0, 3, 4'h0, 32'h0};
    vecs[30] = '{1'b0, 3'd2, 32'h00,  32'h0,        32'h00008001, 1'b0, 3, 4'h0, 32'h0};

    ops[0] = '{1'b1, 3'd2, 32'h40, 32'h11111111, 32'h0};
    ops[1] = '{1'b0, 3'd2, 32'h40, 32'h0,        32'h11111111};
    ops[2] = '{1'b1, 3'd0, 32'h41, 32'h000000AA, 32'h0};
    ops[3] = '{1'b0, 3'd2, 32'h40, 32'h0,        32'h1111AA11};
    ops[4] = '{1'b1, 3'd1, 32'h42, 32'h00007777, 32'h0};
    ops[5] = '{1'b0, 3'd5, 32'h42, 32'h0,        32'h00007777};

    // Reset values while RESETN is low.
    repeat (3) @(negedge CLK);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_wmask", 32'(mem_wmask), 32'd0);
    chk("rst_rstrb", 32'(mem_rstrb), 32'd0);
    chk("rst_leds", 32'(leds), 32'd0);
    RESETN = 1'b1;
    @(negedge CLK);
    chk("post_rst_ready", 32'(req_ready), 32'd1);

    for (int i = 0; i < NV; i++) begin
      do_req(vecs[i].st, vecs[i].f3, vecs[i].addr, vecs[i].wd, lat, rd, er, nr, nw, wm, wdat, ma);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rd);
      chk($sformatf("v%0d_error", i), 32'(er), 32'(vecs[i].exp_er));
      chk($sformatf("v%0d_rstrb_cycles", i), 32'(nr), (vecs[i].exp_lat == 3) ? 32'd1 : 32'd0);
      chk($sformatf("v%0d_wmask_cycles", i), 32'(nw), (vecs[i].exp_lat == 2) ? 32'd1 : 32'd0);
      if (vecs[i].exp_lat == 2) begin
        chk($sformatf("v%0d_wmask", i), 32'(wm), 32'(vecs[i].exp_wm));
        chk($sformatf("v%0d_wdata", i), wdat, vecs[i].exp_wdat);
      end
      if (vecs[i].exp_lat >= 2) begin
        a_tmp = vecs[i].addr;
        chk($sformatf("v%0d_mem_addr", i), 32'(ma), 32'(a_tmp[9:2]));
      end
    end

`ifdef LSU_IO_EN
    do_req(1'b1, 3'd2, 32'h400000, 32'h0000000A, lat, rd, er, nr, nw, wm, wdat, ma);
    chk("io_sw_led_latency", 32'(lat), 32'd1);
    chk("io_sw_led_error", 32'(er), 32'd0);
    chk("io_leds", 32'(leds), 32'hA);
    chk("io_sw_no_ram", 32'(nw + nr), 32'd0);
    do_req(1'b0, 3'd2, 32'h400000, 32'h0, lat, rd, er, nr, nw, wm, wdat, ma);
    chk("io_lw_led", rd, 32'h0000000A);
    do_req(1'b0, 3'd2, 32'h400004, 32'h0, lat, v1, er, nr, nw, wm, wdat, ma);
    repeat (8) @(negedge CLK);
    do_req(1'b0, 3'd2, 32'h400004, 32'h0, lat, v2, er, nr, nw, wm, wdat, ma);
    chk("io_counter_delta", v2 - v1, 32'd10);
    do_req(1'b1, 3'd0, 32'h400000, 32'h5, lat, rd, er, nr, nw, wm, wdat, ma);
    chk("io_sb_error", 32'(er), 32'd1);
    chk("io_sb_latency", 32'(lat), 32'd1);
    do_req(1'b0, 3'd1, 32'h400000, 32'h0, lat, rd, er, nr, nw, wm, wdat, ma);
    chk("io_lh_error", 32'(er), 32'd1);
    do_req(1'b1, 3'd2, 32'h400004, 32'h5, lat, rd, er, nr, nw, wm, wdat, ma);
    chk("io_sw_counter_error", 32'(er), 32'd0);
    chk("io_leds_kept", 32'(leds), 32'hA);
    do_req(1'b0, 3'd2, 32'h400008, 32'h0, lat, rd, er, nr, nw, wm, wdat, ma);
    chk("io_other_offset", rd, 32'd0);
`else
    do_req(1'b1, 3'd2, 32'h400000, 32'h0000000A, lat, rd, er, nr, nw, wm, wdat, ma);
    chk("alias_sw_latency", 32'(lat), 32'd2);
    chk("alias_leds_tied", 32'(leds), 32'd0);
    do_req(1'b1, 3'd0, 32'h400001, 32'h0, lat, rd, er, nr, nw, wm, wdat, ma);
    chk("alias_sb_error", 32'(er), 32'd0);
    do_req(1'b0, 3'd2, 32'h0, 32'h0, lat, rd, er, nr, nw, wm, wdat, ma);
    chk("alias_lw", rd, 32'h0000000A);
`endif

    // Reset asserted during the WRITE cycle drops the store.
    @(negedge CLK);
    drive(1'b1, 3'd2, 32'h30, 32'h55555555);
    req_valid = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    req_valid = 1'b0;
    chk("wr_rst_wmask_before", 32'(mem_wmask), 32'hF);
    RESETN = 1'b0;
    #1;
    chk("wr_rst_wmask_gated", 32'(mem_wmask), 32'd0);
    chk("wr_rst_ready_low", 32'(req_ready), 32'd0);
    @(negedge CLK);
    chk("wr_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("wr_rst_wmask", 32'(mem_wmask), 32'd0);
    chk("wr_rst_leds", 32'(leds), 32'd0);
    RESETN = 1'b1;
    @(negedge CLK);
    chk("wr_rst_ready_after", 32'(req_ready), 32'd1);
    chk("wr_rst_no_rsp", 32'(rsp_valid), 32'd0);
    @(negedge CLK);
    chk("wr_rst_no_rsp2", 32'(rsp_valid), 32'd0);
    do_req(1'b0, 3'd2, 32'h30, 32'h0, lat, rd, er, nr, nw, wm, wdat, ma);
    chk("wr_rst_ram_unchanged", rd, 32'd0);

    // req_valid held high across alternating loads and stores.
    @(negedge CLK);
    k = 0;
    drive(ops[0].st, ops[0].f3, ops[0].a, ops[0].wd);
    req_valid = 1'b1;
    acc = 0; rsps = 0; pend = 1'b0; tmo = 0;
    pend = req_valid && req_ready;
    while ((acc < 6 || rsps < 6) && tmo < 100) begin
      @(negedge CLK);
      tmo++;
      if (pend) begin
        acc++;
        k++;
        if (k < 6) drive(ops[k].st, ops[k].f3, ops[k].a, ops[k].wd);
        else req_valid = 1'b0;
      end
      if (rsp_valid) begin
        if (rsps < 6) chk($sformatf("b2b_rdata%0d", rsps), rsp_rdata, ops[rsps].rd);
        chk("b2b_ready_in_resp", 32'(req_ready), 32'd0);
        rsps++;
      end
      pend = req_valid && req_ready;
    end
    req_valid = 1'b0;
    repeat (4) begin
      @(negedge CLK);
      if (rsp_valid) rsps++;
    end
    chk("b2b_accepts", 32'(acc), 32'd6);
    chk("b2b_responses", 32'(rsps), 32'd6);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit sitting directly downstream of the multi-cycle RV32I core's EXECUTE stage, between the core and the 256-word instruction/data RAM. It accepts one load or store request at a time and handles byte/halfword/word alignment, byte-lane masking and sign/zero extension. It also decodes a small memory-mapped IO page that drives the board LEDs and exposes a cycle counter.

## Interface
- ADDR_WIDTH, 8, RAM word-address bits (2^ADDR_WIDTH words)
- CLK  in  1  system clock, rising edge
- RESETN  in  1  synchronous, active-low reset
- req_valid  in  1  core presents a request
- req_ready  out  1  unit idle; request accepted on `req_valid && req_ready`
- req_is_store  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
- req_addr  in  32  byte address (rs1 + imm)
- req_wdata  in  32  store data (rs2)
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_error  out  1  misaligned or illegal funct3; qualified by rsp_valid
- mem_addr  out  ADDR_WIDTH  RAM word address
- mem_wdata  out  32  RAM write data, lane-replicated
- mem_wmask  out  4  RAM byte write enables
- mem_rstrb  out  1  RAM read strobe
- mem_rdata  in  32  RAM read data, valid the cycle after mem_rstrb
- leds  out  4  LED register

## Operation
- States: IDLE, READ, WAIT, WRITE, RESP. `req_ready = (state == IDLE) && RESETN`.
- On accept, register funct3, addr, wdata and is_store. Inputs are don't-care after accept.
- Error check on accept:
  - Halfword with addr[0] = 1, or word with addr[1:0] != 0, is an error.
  - Load funct3 3/6/7 and store funct3 3–7 are errors.
  - Error path: IDLE -> RESP with rsp_error = 1. No RAM strobe, no write.
- IO page: req_addr[22] = 1.
  - Only LW/SW are legal; any other width is an error.
  - Word offset 0 is LEDs: SW writes wdata[3:0], LW returns {28'b0, leds}.
  - Offset 4 is the cycle counter: read-only, 32-bit, free-running, wraps to 0, reset to 0. Writes are ignored.
  - Other offsets read 0; writes are ignored.
  - IO path: IDLE -> RESP.
- RAM load path: IDLE -> READ (mem_rstrb = 1) -> WAIT (capture mem_rdata) -> RESP.
  - Captured word is shifted right by 8*addr[1:0].
  - LB/LH sign-extend bit 7/15; LBU/LHU zero-extend.
- RAM store path: IDLE -> WRITE (mem_wmask active for exactly one cycle) -> RESP.
  - SB: wdata[7:0] replicated to all 4 lanes, wmask = 4'b0001 << addr[1:0].
  - SH: wdata[15:0] replicated to both halves, wmask = 4'b0011 << addr[1:0].
  - SW: wmask = 4'b1111.
- `mem_addr = addr[ADDR_WIDTH+1:2]`. Upper bits are ignored, so RAM aliases (wraps) across the space.
- RESP: rsp_valid = 1 for one cycle, then IDLE.
- Outside READ, mem_rstrb = 0. Outside WRITE, mem_wmask = 0.

## Timing
- Request accepted at edge 0. rsp_valid is high in cycle:
  - 3 for RAM loads,
  - 2 for RAM stores,
  - 1 for IO accesses and errors.
- rsp_rdata and rsp_error are registered and stable while rsp_valid is high. Both are 0 otherwise.
- req_ready is low from the accept edge until the cycle after RESP. No back-to-back accept in the RESP cycle.
- req_valid while busy is ignored. The core holds req_valid until accepted.
- RESETN low at any edge:
  - state -> IDLE; leds, rsp_*, mem_wmask, mem_rstrb and the counter -> 0.
  - Any in-flight transaction is dropped with no RAM write and no rsp_valid.
- While RESETN is low, req_ready = 0.
- Counter increments every cycle RESETN is high. An LW of offset 4 returns the value registered at the accept edge.

## Configuration
- `LSU_IO_EN` defined: IO page decode, leds register and cycle counter are present, as described above.
- `LSU_IO_EN` undefined:
  - addr[22] is ignored and every access goes to RAM (aliased); sub-word IO restrictions do not apply.
  - leds is tied to 4'b0.
  - The counter is not built.

## Test plan
- SW 0x12345678 @0x10, then LB @0x13 and LBU @0x13 -> rsp_rdata 0x00000012 both. LB @0x10 after SB 0x80 @0x10 -> 0xFFFFFF80. LBU -> 0x00000080.
- SH 0xBEEF @0x22 -> mem_wmask 4'b1100, mem_wdata 0xBEEFBEEF. LH @0x22 -> 0xFFFFBEEF. LHU -> 0x0000BEEF. RAM-load rsp_valid 3 cycles after accept.
- LW @0x02, LH @0x01, SH @0x03 -> rsp_error = 1 at cycle 1, mem_rstrb and mem_wmask never asserted, RAM contents unchanged.
- With LSU_IO_EN: SW 0xA @0x400000 -> leds = 4'hA. LW @0x400000 -> 0x0000000A. Two LW @0x400004 accepted 10 cycles apart -> values differ by 10. SB @0x400000 -> error.
- Store accepted, RESETN pulled low in the WRITE cycle -> no wmask edge commits, no rsp_valid, req_ready = 1 the cycle after RESETN returns high.
- req_valid held high continuously with alternating load/store -> exactly one rsp_valid per accept, each accept only when req_ready = 1.
